e_mdu: RTL and testbench

Execute-stage multiply/divide unit of the P7 pipeline: owns the HI/LO registers and runs mult/multu/div/divu as a fixed-latency multi-cycle operation. It also services mthi/mtlo/mfhi/mflo. Sits beside the ALU in E; its `MD_O` is the E-stage multiply/divide read result selected into the E→M pipeline register. `Busy` and `Start` go to the hazard unit. `Req` suppresses any E-stage write to HI/LO when the E instruction is flushed by an exception/interrupt.

---
 rtl/e_mdu.sv | 140 ++++++++++++++
 tb/tb_e_mdu.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: owns HI/LO, runs mult/div as a fixed-latency
// operation whose result is computed at start and committed when the busy window ends.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic [3:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MD_O,
  output logic        dbg_state
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = ($clog2(MAX_CYC + 1) > 4) ? $clog2(MAX_CYC + 1) : 4;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Handshake: Start is the single-cycle accept of a mult/div; it is only
  // possible while idle and when the E-stage instruction is not being flushed.
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, lo_q, phi_q, plo_q;
  logic               pdz_q;
  logic               commit;
  logic               is_mul, is_div, mt_ok;
  logic [31:0]        res_hi, res_lo;
  logic [63:0]        prod_s, prod_u;
  logic signed [32:0] sa33, sb33, sq33, sr33;
  logic [31:0]        b_safe, uq, ur;

  assign is_mul = (MDOp == OP_MULT) || (MDOp == OP_MULTU);
  assign is_div = (MDOp == OP_DIV) || (MDOp == OP_DIVU);
  assign Start  = (is_mul || is_div) && !Req && (state_q == IDLE);
  assign mt_ok  = !Req && (state_q == IDLE);

  assign Busy      = (state_q == RUN);
  assign dbg_state = state_q;
  assign HI        = hi_q;
  assign LO        = lo_q;

  always_comb begin
    MD_O = 32'd0;
    if (MDOp == OP_MFHI) MD_O = hi_q;
    else if (MDOp == OP_MFLO) MD_O = lo_q;
  end

  // Divisor forced nonzero so the datapath never divides by zero; the
  // divide-by-zero case is suppressed at commit instead.
  assign b_safe = (B == 32'd0) ? 32'd1 : B;
  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'd0, A} * {32'd0, B};
  assign sa33   = $signed({A[31], A});
  assign sb33   = $signed({b_safe[31], b_safe});
  assign sq33   = sa33 / sb33;
  assign sr33   = sa33 % sb33;
  assign uq     = A / b_safe;
  assign ur     = A % b_safe;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (MDOp)
      OP_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
      OP_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
      OP_DIV:   begin res_hi = sr33[31:0];    res_lo = sq33[31:0];   end
      OP_DIVU:  begin res_hi = ur;            res_lo = uq;           end
      default:  ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = RUN;
          cnt_d   = is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      phi_q   <= 32'd0;
      plo_q   <= 32'd0;
      pdz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (Start) begin
        phi_q <= res_hi;
        plo_q <= res_lo;
        pdz_q <= is_div && (B == 32'd0);
      end
      // Commit only happens in RUN and mthi/mtlo only when idle, so they never collide.
      if (commit) begin
        if (!pdz_q) begin
          hi_q <= phi_q;
          lo_q <= plo_q;
        end
      end else begin
        if (mt_ok && (MDOp == OP_MTHI)) hi_q <= A;
        if (mt_ok && (MDOp == OP_MTLO)) lo_q <= A;
      end
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// Randomized bench for e_mdu against an arithmetic reference model of HI/LO.
module tb_e_mdu;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset, Req;
  logic [3:0]  MDOp;
  logic [31:0] A, B;
  logic        Start, Busy, dbg_state;
  logic [31:0] HI, LO, MD_O;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] m_hi, m_lo;
  logic [63:0] exp_q[$];

  e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .Req(Req), .MDOp(MDOp), .A(A), .B(B),
    .Start(Start), .Busy(Busy), .HI(HI), .LO(LO), .MD_O(MD_O), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    Req = 1'b0; MDOp = 4'd0; A = 32'd0; B = 32'd0;
  endtask

  // Reference: full-width arithmetic; division truncates toward zero in SV.
  function automatic logic [63:0] ref_md(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] hi,
                                         input logic [31:0] lo);
    longint q, r;
    longint unsigned ua, ub, uq, ur;
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      4'd1: begin q = longint'($signed(a)) * longint'($signed(b)); return q; end
      4'd2: return ua * ub;
      4'd3: begin
        if (b == 32'd0) return {hi, lo};
        q = longint'($signed(a)) / longint'($signed(b));
        r = longint'($signed(a)) % longint'($signed(b));
        return {r[31:0], q[31:0]};
      end
      4'd4: begin
        if (b == 32'd0) return {hi, lo};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      default: return {hi, lo};
    endcase
  endfunction

  task automatic do_reset();
    idle_in();
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    exp_q.delete();
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    MDOp = 4'd7;
    #1;
    chk("rst_mfhi", MD_O, 32'd0);
    MDOp = 4'd0;
  endtask

  // Start a mult/div, watch the full busy window, then check the commit.
  task automatic md_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit noisy);
    int n;
    logic [63:0] r;
    n = (op <= 4'd2) ? MC : DC;
    MDOp = op; A = a; B = b; Req = 1'b0;
    #1;
    chk("start", 32'(Start), 32'd1);
    exp_q.push_back(ref_md(op, a, b, m_hi, m_lo));
    step();
    idle_in();
    for (int i = 0; i < n; i++) begin
      chk("busy", 32'(Busy), 32'd1);
      chk("hold_hi", HI, m_hi);
      chk("hold_lo", LO, m_lo);
      if (noisy) begin
        MDOp = 4'($urandom_range(1, 6));
        A = $urandom; B = $urandom;
        Req = 1'($urandom_range(0, 1));
        #1;
        chk("start_busy", 32'(Start), 32'd0);
      end
      step();
      idle_in();
    end
    r = exp_q.pop_front();
    m_hi = r[63:32];
    m_lo = r[31:0];
    chk("busy_end", 32'(Busy), 32'd0);
    chk("res_hi", HI, m_hi);
    chk("res_lo", LO, m_lo);
  endtask

  task automatic mt_op(input logic [3:0] op, input logic [31:0] a, input logic req);
    MDOp = op; A = a; Req = req;
    step();
    idle_in();
    if (!req && op == 4'd5) m_hi = a;
    if (!req && op == 4'd6) m_lo = a;
    MDOp = 4'd7;
    #1;
    chk("mfhi", MD_O, m_hi);
    MDOp = 4'd8;
    #1;
    chk("mflo", MD_O, m_lo);
    MDOp = 4'd0;
  endtask

  task automatic req_start(input logic [3:0] op);
    MDOp = op; A = $urandom; B = $urandom; Req = 1'b1;
    #1;
    chk("req_start", 32'(Start), 32'd0);
    step();
    idle_in();
    chk("req_busy", 32'(Busy), 32'd0);
    chk("req_hi", HI, m_hi);
    chk("req_lo", LO, m_lo);
  endtask

  initial begin
    logic [31:0] ra, rb;
    int sel;
    idle_in();
    reset = 1'b1;
    step();
    do_reset();

    md_op(4'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
    chk("mult_hi_const", HI, 32'hFFFFFFFF);
    chk("mult_lo_const", LO, 32'hFFFFFFFA);
    md_op(4'd2, 32'hFFFFFFFE, 32'd3, 1'b0);
    chk("multu_hi_const", HI, 32'h00000002);
    chk("multu_lo_const", LO, 32'hFFFFFFFA);
    md_op(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
    chk("div_lo_const", LO, 32'hFFFFFFFD);
    chk("div_hi_const", HI, 32'hFFFFFFFF);
    md_op(4'd4, 32'd7, 32'd0, 1'b0);
    chk("divz_hi_const", HI, 32'hFFFFFFFF);
    md_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    chk("ovf_lo_const", LO, 32'h80000000);
    chk("ovf_hi_const", HI, 32'd0);

    mt_op(4'd5, 32'h12345678, 1'b0);
    chk("mthi_const", HI, 32'h12345678);
    mt_op(4'd6, 32'hDEADBEEF, 1'b1);
    req_start(4'd1);
    md_op(4'd1, 32'd1000, 32'hFFFFFFFF, 1'b1);

    // Reset during the fourth busy cycle of a div aborts it with no commit.
    MDOp = 4'd3; A = 32'd100; B = 32'd7;
    step();
    idle_in();
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    repeat (DC) step();
    chk("abort_late_hi", HI, 32'd0);
    chk("abort_late_lo", LO, 32'd0);

    MDOp = 4'd12;
    #1;
    chk("nop_mdo", MD_O, 32'd0);
    chk("nop_start", 32'(Start), 32'd0);
    MDOp = 4'd0;

    for (int k = 0; k < 30; k++) begin
      sel = $urandom_range(0, 9);
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 :
           ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if ($urandom_range(0, 7) == 0) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
      if (sel < 6) md_op(4'(sel % 4 + 1), ra, rb, 1'($urandom_range(0, 1)));
      else if (sel < 9) mt_op(4'(5 + (sel % 2)), ra, 1'($urandom_range(0, 1)));
      else req_start(4'($urandom_range(1, 4)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
